reset_sequencer: RTL and testbench

Reset sequencer at the DUT end of the testbench reset interface. It receives the raw reset driven onto `rst` by the reset master, synchronizes its deassertion to `clk`, and holds all downstream resets for a fixed time. It then releases a set of per-stage resets in order, with a fixed gap between stages, and reports completion. It also accepts a software soft-reset request that reruns the hold and release sequence without a hard reset.

---
 rtl/reset_sequencer_if.sv | 38 +++
 rtl/reset_sequencer.sv | 208 ++++++++++++++++++++
 tb/tb_reset_sequencer.sv | 175 +++++++++++++++++
 3 files changed

// File: rtl/reset_sequencer_if.sv
// -----------------------------------------------------------------------------
// reset_sequencer_if
// Groups the soft-reset handshake and the sequenced reset outputs of the
// reset sequencer into one bundle.
//   sw_rst_req  : soft-reset request level (master -> slave)
//   sw_rst_ack  : one-cycle acknowledge of an accepted soft reset
//   stage_rst_n : per-stage active-low resets, released lowest index first
//   rst_done    : high once every stage is released
//   rst_count   : saturating count of accepted soft resets
// The slave modport is the sequencer side; the master modport is the side
// that requests soft resets and consumes the stage resets.
// -----------------------------------------------------------------------------
interface reset_sequencer_if #(
    parameter int NUM_STAGES = 4,
    parameter int CNT_W      = 8
);
    logic                  sw_rst_req;
    logic                  sw_rst_ack;
    logic [NUM_STAGES-1:0] stage_rst_n;
    logic                  rst_done;
    logic [CNT_W-1:0]      rst_count;

    modport master (
        output sw_rst_req,
        input  sw_rst_ack,
        input  stage_rst_n,
        input  rst_done,
        input  rst_count
    );

    modport slave (
        input  sw_rst_req,
        output sw_rst_ack,
        output stage_rst_n,
        output rst_done,
        output rst_count
    );
endinterface

// File: rtl/reset_sequencer.sv
// -----------------------------------------------------------------------------
// reset_sequencer
// Takes the raw active-low reset, synchronizes its deassertion to clk through
// a two-flop chain, holds every downstream reset for HOLD_CYCLES edges, then
// releases the stage resets one by one (STAGE_GAP edges apart) and flags
// completion. A soft-reset request accepted in DONE reruns hold + release
// without touching the synchronizer.
// Ports:
//   clk : single rising-edge clock
//   rst : asynchronous active-low reset; clears every register immediately
//   bus : reset_sequencer_if.slave (sw_rst_req in; sw_rst_ack, stage_rst_n,
//         rst_done, rst_count out). All outputs come straight from flops so
//         nothing glitches when rst deasserts.
// -----------------------------------------------------------------------------
module reset_sequencer #(
    parameter int NUM_STAGES  = 4,
    parameter int HOLD_CYCLES = 16,
    parameter int STAGE_GAP   = 4,
    parameter int CNT_W       = 8
) (
    input  logic               clk,
    input  logic               rst,
    reset_sequencer_if.slave   bus
);

    // Timer width covers the larger of the two intervals with one spare bit.
    localparam int SPAN_MAX = (HOLD_CYCLES > STAGE_GAP) ? HOLD_CYCLES : STAGE_GAP;
    localparam int TW       = $clog2(SPAN_MAX) + 1;

    localparam logic [TW-1:0]         HOLD_LAST  = TW'(HOLD_CYCLES - 1);
    localparam logic [TW-1:0]         GAP_LAST   = TW'(STAGE_GAP - 1);
    localparam logic [TW-1:0]         TIMER_ZERO = TW'(0);
    localparam logic [CNT_W-1:0]      CNT_MAX    = {CNT_W{1'b1}};
    localparam logic [NUM_STAGES-1:0] STAGES_LOW = {NUM_STAGES{1'b0}};

    typedef enum logic [2:0] {
        ST_ASSERT  = 3'd0,
        ST_SYNC    = 3'd1,
        ST_HOLD    = 3'd2,
        ST_RELEASE = 3'd3,
        ST_DONE    = 3'd4
    } state_t;

    state_t                state_r;
    state_t                state_s;
    logic [1:0]            sync_r;
    logic [TW-1:0]         hold_cnt_r;
    logic [TW-1:0]         hold_cnt_s;
    logic [TW-1:0]         gap_cnt_r;
    logic [TW-1:0]         gap_cnt_s;
    logic [NUM_STAGES-1:0] stage_r;
    logic [NUM_STAGES-1:0] stage_s;
    logic                  done_r;
    logic                  done_s;
    logic                  ack_r;
    logic                  ack_s;
    logic [CNT_W-1:0]      count_r;
    logic [CNT_W-1:0]      count_s;
    logic                  req_r;
    logic                  accept_s;

    // Saturating increment for the soft-reset event counter.
    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] value);
        logic [CNT_W-1:0] result;
        if (value == CNT_MAX) begin
            result = value;
        end else begin
            result = value + CNT_W'(1);
        end
        return result;
    endfunction

    // Shifts a 1 in at bit 0. Stages form a thermometer code, so this always
    // releases exactly the next stage and can never release one out of order.
    function automatic logic [NUM_STAGES-1:0] next_stage(input logic [NUM_STAGES-1:0] value);
        return NUM_STAGES'({value, 1'b1});
    endfunction

    // Reset synchronizer: async clear, shifts 1s in once rst is released.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            sync_r <= 2'b00;
        end else begin
            sync_r <= {sync_r[0], 1'b1};
        end
    end

    // FSM state register.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_r <= ST_ASSERT;
        end else begin
            state_r <= state_s;
        end
    end

    // Soft-reset request sample; only a request seen while in DONE counts,
    // so a request raised during HOLD/RELEASE cannot be carried into DONE.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            req_r <= 1'b0;
        end else begin
            req_r <= bus.sw_rst_req && (state_r == ST_DONE);
        end
    end

    // Next-state and next-output logic.
    always_comb begin
        state_s    = state_r;
        hold_cnt_s = hold_cnt_r;
        gap_cnt_s  = gap_cnt_r;
        stage_s    = stage_r;
        done_s     = done_r;
        ack_s      = 1'b0;
        count_s    = count_r;
        accept_s   = (state_r == ST_DONE) && req_r;

        case (state_r)
            ST_ASSERT: begin
                state_s = ST_SYNC;
            end

            ST_SYNC: begin
                // First flop already 1, second about to take it: leave SYNC
                // on the same edge the synchronized reset deasserts.
                if (sync_r[0] && !sync_r[1]) begin
                    state_s    = ST_HOLD;
                    hold_cnt_s = TIMER_ZERO;
                end else begin
                    state_s = ST_SYNC;
                end
            end

            ST_HOLD: begin
                if (hold_cnt_r == HOLD_LAST) begin
                    state_s    = ST_RELEASE;
                    stage_s    = next_stage(STAGES_LOW);
                    gap_cnt_s  = TIMER_ZERO;
                    hold_cnt_s = TIMER_ZERO;
                end else begin
                    hold_cnt_s = hold_cnt_r + TW'(1);
                end
            end

            ST_RELEASE: begin
                if (stage_r[NUM_STAGES-1]) begin
                    state_s   = ST_DONE;
                    done_s    = 1'b1;
                    gap_cnt_s = TIMER_ZERO;
                end else if (gap_cnt_r == GAP_LAST) begin
                    stage_s   = next_stage(stage_r);
                    gap_cnt_s = TIMER_ZERO;
                end else begin
                    gap_cnt_s = gap_cnt_r + TW'(1);
                end
            end

            ST_DONE: begin
                // Soft reset goes straight to HOLD: the synchronizer is
                // already settled, so SYNC is not revisited.
                if (accept_s) begin
                    state_s    = ST_HOLD;
                    stage_s    = STAGES_LOW;
                    done_s     = 1'b0;
                    ack_s      = 1'b1;
                    count_s    = sat_inc(count_r);
                    hold_cnt_s = TIMER_ZERO;
                    gap_cnt_s  = TIMER_ZERO;
                end else begin
                    state_s = ST_DONE;
                end
            end

            default: begin
                state_s    = ST_ASSERT;
                stage_s    = STAGES_LOW;
                done_s     = 1'b0;
                hold_cnt_s = TIMER_ZERO;
                gap_cnt_s  = TIMER_ZERO;
            end
        endcase
    end

    // Timers and registered outputs.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            hold_cnt_r <= TIMER_ZERO;
            gap_cnt_r  <= TIMER_ZERO;
            stage_r    <= STAGES_LOW;
            done_r     <= 1'b0;
            ack_r      <= 1'b0;
            count_r    <= {CNT_W{1'b0}};
        end else begin
            hold_cnt_r <= hold_cnt_s;
            gap_cnt_r  <= gap_cnt_s;
            stage_r    <= stage_s;
            done_r     <= done_s;
            ack_r      <= ack_s;
            count_r    <= count_s;
        end
    end

    assign bus.stage_rst_n = stage_r;
    assign bus.rst_done    = done_r;
    assign bus.sw_rst_ack  = ack_r;
    assign bus.rst_count   = count_r;

endmodule

// File: tb/tb_reset_sequencer.sv
// -----------------------------------------------------------------------------
// tb_reset_sequencer
// Two sequencers share clk, rst and the soft-reset request: one with the
// default timing and a 2-bit event counter (saturation), one with every
// parameter at 1 (corner case). The reference model works in edge numbers:
// it tracks the edge count since deassertion and the edge at which the
// current hold started, and derives every expected output from the timing
// formulas directly.
// -----------------------------------------------------------------------------
module tb_reset_sequencer;

    logic clk;
    logic rst;
    logic req;

    int total = 0;
    int bad   = 0;

    // Per-DUT parameters: index 0 = default timing, index 1 = corner.
    int p_n  [2] = '{4, 1};
    int p_h  [2] = '{16, 1};
    int p_g  [2] = '{4, 1};
    int p_cw [2] = '{2, 8};

    // Model state.
    int m_n    [2];   // edges since rst deasserted
    int m_h    [2];   // edge on which the current HOLD began
    int m_cnt  [2];
    bit m_samp [2];   // request seen at the previous edge while in DONE
    bit m_ack  [2];

    reset_sequencer_if #(.NUM_STAGES(4), .CNT_W(2)) if_a ();
    reset_sequencer_if #(.NUM_STAGES(1), .CNT_W(8)) if_b ();

    assign if_a.sw_rst_req = req;
    assign if_b.sw_rst_req = req;

    reset_sequencer #(.NUM_STAGES(4), .HOLD_CYCLES(16), .STAGE_GAP(4), .CNT_W(2)) dut_a (
        .clk (clk),
        .rst (rst),
        .bus (if_a.slave)
    );

    reset_sequencer #(.NUM_STAGES(1), .HOLD_CYCLES(1), .STAGE_GAP(1), .CNT_W(8)) dut_b (
        .clk (clk),
        .rst (rst),
        .bus (if_b.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic bit m_done(int d);
        return m_n[d] >= m_h[d] + p_h[d] + (p_n[d] - 1) * p_g[d] + 1;
    endfunction

    function automatic int m_stages(int d);
        int v = 0;
        for (int k = 0; k < p_n[d]; k++) begin
            if (m_n[d] >= m_h[d] + p_h[d] + k * p_g[d]) v |= (1 << k);
        end
        return v;
    endfunction

    task automatic model_reset();
        for (int d = 0; d < 2; d++) begin
            m_n[d]    = 0;
            m_h[d]    = 2;
            m_cnt[d]  = 0;
            m_samp[d] = 1'b0;
            m_ack[d]  = 1'b0;
        end
    endtask

    task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    task automatic check_all(string tag);
        chk({tag, " a.stage"}, 32'(if_a.stage_rst_n), m_stages(0));
        chk({tag, " a.done"},  32'(if_a.rst_done),    32'(m_done(0)));
        chk({tag, " a.ack"},   32'(if_a.sw_rst_ack),  32'(m_ack[0]));
        chk({tag, " a.count"}, 32'(if_a.rst_count),   m_cnt[0]);
        chk({tag, " b.stage"}, 32'(if_b.stage_rst_n), m_stages(1));
        chk({tag, " b.done"},  32'(if_b.rst_done),    32'(m_done(1)));
        chk({tag, " b.ack"},   32'(if_b.sw_rst_ack),  32'(m_ack[1]));
        chk({tag, " b.count"}, 32'(if_b.rst_count),   m_cnt[1]);
    endtask

    // One clock edge with rst high; inputs were set at the preceding negedge.
    task automatic tick(string tag);
        bit dpre [2];
        bit acc;
        for (int d = 0; d < 2; d++) dpre[d] = m_done(d);
        @(posedge clk);
        for (int d = 0; d < 2; d++) begin
            m_n[d]++;
            acc       = dpre[d] && m_samp[d];
            m_samp[d] = dpre[d] && req;
            if (acc) begin
                m_h[d]   = m_n[d];
                m_cnt[d] = (m_cnt[d] == (1 << p_cw[d]) - 1) ? m_cnt[d] : m_cnt[d] + 1;
            end
            m_ack[d] = acc;
        end
        @(negedge clk);
        check_all(tag);
    endtask

    // Called at a negedge: asserts rst and checks the asynchronous clear.
    task automatic hard_reset(string tag, int cycles);
        rst = 1'b0;
        #1;
        model_reset();
        check_all({tag, " async"});
        for (int i = 0; i < cycles; i++) begin
            @(negedge clk);
            check_all({tag, " held"});
        end
        rst = 1'b1;
    endtask

    initial begin
        rst = 1'b0;
        req = 1'b0;
        model_reset();
        @(negedge clk);
        check_all("reset");
        @(negedge clk);
        check_all("reset");

        // Power-on sequence: A releases at 18/22/26/30, done at 31;
        // B releases at 3, done at 4.
        rst = 1'b1;
        for (int i = 0; i < 35; i++) tick("poweron");

        // Single-cycle soft-reset pulse from DONE.
        req = 1'b1;
        tick("soft_pulse");
        req = 1'b0;
        for (int i = 0; i < 34; i++) tick("soft_run");

        // Request held high through HOLD/RELEASE: one accept per DONE entry,
        // and A's 2-bit counter saturates along the way.
        req = 1'b1;
        for (int i = 0; i < 140; i++) tick("soft_held");
        req = 1'b0;
        for (int i = 0; i < 35; i++) tick("soft_drain");

        // Hard reset at edge 24 with A stages 0011 released.
        hard_reset("mid_hard", 3);
        for (int i = 0; i < 24; i++) tick("pre_mid");
        hard_reset("mid_at24", 2);
        for (int i = 0; i < 35; i++) tick("restart");

        // Randomized requests and occasional hard resets.
        for (int i = 0; i < 600; i++) begin
            req = ($urandom_range(0, 3) == 0);
            if ($urandom_range(0, 79) == 0) begin
                hard_reset("rand_hard", $urandom_range(0, 2));
            end
            tick("random");
        end
        req = 1'b0;
        for (int i = 0; i < 35; i++) tick("final");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
